// File: rtl/dmem_stall_ctrl.sv
// MEM-stage sequencer for a variable-latency req/ack data memory: issues each
// load/store once, stalls the pipeline while outstanding, aborts on timeout.
// Optional performance counters are enabled with `define DMEM_PERF_CNT_EN.
`timescale 1ns/1ps

module dmem_stall_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       access_cnt_o,
    output logic [1:0]        state_o
);

    // Handshake: mem_req_o stays high from the first WAIT cycle until the
    // edge on which mem_ack_i (a one-cycle pulse) is sampled or the timeout
    // fires; address, write data and direction are stable while it is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            mem_op;
    logic            wait_end;

    assign mem_op   = start_i & (memRead_i | memWrite_i);
    assign wait_end = (state == WAIT) & (mem_ack_i | (to_cnt == TO_LAST));
    assign state_o  = state;

    // Stall is combinational in IDLE so the access is frozen on its first cycle.
    assign stall_o = ~rst_i & ((state == WAIT) | ((state == IDLE) & mem_op));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            to_cnt      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= memWrite_i;
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        to_cnt      <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        state <= DONE;
                    end else if (to_cnt == TO_LAST) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // EX/MEM still holds the finished instruction; do not re-issue.
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] access_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt  <= '0;
            access_cnt <= '0;
        end else begin
            if (stall_o) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (wait_end) begin
                access_cnt <= access_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign access_cnt_o = access_cnt;
`else
    logic unused_wait_end;
    assign unused_wait_end = wait_end;
    assign stall_cnt_o     = '0;
    assign access_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Randomised bench for dmem_stall_ctrl: a cycle-level schedule of each access
// is pushed into exp_q by the driver and popped by a negedge monitor.
`timescale 1ns/1ps

module tb_dmem_stall_ctrl;

    localparam int TO_CYC = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, memRead_i, memWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, err_o;
    logic [31:0] stall_cnt_o, access_cnt_o;
    logic [1:0]  state_o;

    dmem_stall_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .access_cnt_o(access_cnt_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        stall;
        logic        req;
        logic        err;
        logic        fields;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] scnt;
        logic [31:0] acnt;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model: architectural state visible at the ports.
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic [31:0] m_scnt  = '0;
    logic [31:0] m_acnt  = '0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        tests++;
        if (act_v !== req_v) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act_v, req_v, $time);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
            check("mem_req_o", {31'd0, mem_req_o}, {31'd0, e.req});
            check("err_o", {31'd0, err_o}, {31'd0, e.err});
            check("rdata_o", rdata_o, e.rdata);
            check("stall_cnt_o", stall_cnt_o, e.scnt);
            check("access_cnt_o", access_cnt_o, e.acnt);
            if (e.fields) begin
                check("mem_we_o", {31'd0, mem_we_o}, {31'd0, e.we});
                check("mem_addr_o", mem_addr_o, e.addr);
                check("mem_wdata_o", mem_wdata_o, e.wdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_cycle(input logic stall, input logic req, input logic fields,
                              input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.stall  = stall;
        e.req    = req;
        e.err    = m_err;
        e.fields = fields;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.rdata  = m_rdata;
`ifdef DMEM_PERF_CNT_EN
        e.scnt   = m_scnt;
        e.acnt   = m_acnt;
`else
        e.scnt   = '0;
        e.acnt   = '0;
`endif
        exp_q.push_back(e);
        if (stall) m_scnt = m_scnt + 32'd1;
    endtask

    // One access: IDLE (stall), lat+1 WAIT cycles (or TO_CYC on timeout), DONE.
    // lat < 0 means the memory never acknowledges.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rmem);
        int nwait;
        nwait = (lat < 0) ? TO_CYC : lat + 1;
        step();
        start_i = 1'b1; memRead_i = rd; memWrite_i = wr;
        addr_i = addr; wdata_i = wdata;
        mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        push_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < nwait; k++) begin
            step();
            start_i     = 1'($urandom_range(0, 1));
            mem_ack_i   = (lat >= 0) && (k == lat);
            mem_rdata_i = mem_ack_i ? rmem : $urandom;
            push_cycle(1'b1, 1'b1, 1'b1, wr, addr, wdata);
        end
        if (lat < 0) begin
            m_err   = 1'b1;
            m_rdata = '0;
        end else if (!wr) begin
            m_rdata = rmem;
        end
        m_acnt = m_acnt + 32'd1;
        step();
        start_i     = 1'($urandom_range(0, 1));
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic non_mem(input logic start, input logic ack);
        step();
        start_i = start; memRead_i = 1'b0; memWrite_i = 1'b0;
        addr_i = $urandom; wdata_i = $urandom;
        mem_ack_i = ack; mem_rdata_i = $urandom;
        push_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic blocked(input int n, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        for (int k = 0; k < n; k++) begin
            step();
            start_i = 1'b0; memRead_i = rd; memWrite_i = wr;
            addr_i = addr; wdata_i = wdata;
            mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            push_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req_o"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_mem_we_o"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, "_mem_addr_o"}, mem_addr_o, 32'd0);
        check({tag, "_mem_wdata_o"}, mem_wdata_o, 32'd0);
        check({tag, "_rdata_o"}, rdata_o, 32'd0);
        check({tag, "_stall_o"}, {31'd0, stall_o}, 32'd0);
        check({tag, "_err_o"}, {31'd0, err_o}, 32'd0);
        check({tag, "_stall_cnt_o"}, stall_cnt_o, 32'd0);
        check({tag, "_access_cnt_o"}, access_cnt_o, 32'd0);
        check({tag, "_state_idle"}, {30'd0, state_o}, 32'd0);
    endtask

    // Load stuck in WAIT, reset asserted asynchronously between clock edges.
    task automatic reset_mid_wait();
        logic [31:0] a;
        a = $urandom;
        step();
        start_i = 1'b1; memRead_i = 1'b1; memWrite_i = 1'b0;
        addr_i = a; wdata_i = $urandom; mem_ack_i = 1'b0;
        push_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        mem_ack_i = 1'b0;
        push_cycle(1'b1, 1'b1, 1'b1, 1'b0, a, wdata_i);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        m_rdata = '0; m_err = 1'b0; m_scnt = '0; m_acnt = '0;
        step();
        check_reset_outputs("held_rst");
        start_i = 1'b0; memRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) non_mem(1'b1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1; start_i = 1'b0; memRead_i = 1'b0; memWrite_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        non_mem(1'b1, 1'b0);
        mem_op(1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h5);
        non_mem(1'b1, 1'b0);
        mem_op(1'b0, 1'b1, 32'h8, 32'h78, 3, 32'hdead_beef);
        mem_op(1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h1111_2222);
        mem_op(1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h3333_4444);
        mem_op(1'b1, 1'b0, 32'h10, 32'h0, -1, 32'h0);
        non_mem(1'b1, 1'b1);
        non_mem(1'b0, 1'b1);
        mem_op(1'b1, 1'b1, 32'h20, 32'h55, 1, 32'h9999);
        reset_mid_wait();
        blocked(3, 1'b1, 1'b0, 32'h40, 32'h0);
        mem_op(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'habcd);

        for (int i = 0; i < 150; i++) begin
            int kind;
            int sel;
            logic rd, wr;
            logic [31:0] a, d;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 2);
            rd   = (sel != 1);
            wr   = (sel != 0);
            a    = $urandom;
            d    = $urandom;
            if (kind <= 2) begin
                non_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (kind == 3) begin
                blocked($urandom_range(1, 3), rd, wr, a, d);
                mem_op(rd, wr, a, d, $urandom_range(0, TO_CYC - 1), $urandom);
            end else if (kind == 4) begin
                mem_op(rd, wr, a, d, -1, $urandom);
            end else begin
                mem_op(rd, wr, a, d, $urandom_range(0, TO_CYC - 1), $urandom);
            end
        end

        non_mem(1'b0, 1'b0);
        step();
        @(negedge clk_i);
        #1;
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
Sequencer between the MEM stage of the 5-stage pipeline and a variable-latency data memory that uses a req/ack handshake. It issues each load/store held in EX/MEM exactly once and freezes the pipeline while the access is outstanding. It returns load data to MEM/WB and flags memories that never acknowledge.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
TO_W, 8, timeout counter width
TIMEOUT_CYC, 200, WAIT cycles without ack before abort (1..2^TO_W-1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  CPU run enable; low blocks new accesses
memRead_i  in  1  EX/MEM memRead
memWrite_i  in  1  EX/MEM memWrite
addr_i  in  ADDR_W  EX/MEM ALUresult
wdata_i  in  DATA_W  EX/MEM memWriteData
mem_req_o  out  1  request to data memory
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  ADDR_W  request address
mem_wdata_o  out  DATA_W  request write data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
rdata_o  out  DATA_W  load data to MEM/WB
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
err_o  out  1  sticky timeout flag
stall_cnt_o  out  32  stall-cycle count (see Optional Feature)
access_cnt_o  out  32  completed-access count (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): state=IDLE. mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, stall_o=0, err_o=0. Timeout counter and perf counters cleared. Reset mid-transaction abandons the access; no ack is awaited after release.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On start_i & (memRead_i|memWrite_i): stall_o=1 combinationally this cycle.
  - Registers addr_i/wdata_i into mem_addr_o/mem_wdata_o; mem_we_o=memWrite_i (write wins if both are set). Next state WAIT.
  - Otherwise stall_o=0.
- WAIT:
  - mem_req_o=1 and stall_o=1; request fields are held stable.
  - TO counter increments each cycle.
  - On mem_ack_i: for reads, rdata_o<=mem_rdata_i; for writes, rdata_o unchanged. Deassert mem_req_o next cycle, then go to DONE.
  - If the counter reaches TIMEOUT_CYC with no ack: deassert req, err_o<=1, rdata_o<=0, go to DONE.
  - start_i low does not abort WAIT.
- DONE:
  - stall_o=0, mem_req_o=0. The pipeline advances at the end of this cycle.
  - EX/MEM inputs are ignored because they still hold the completed instruction.
  - Next state IDLE, TO counter cleared.
- Latency: a memory op stalls for 2+L cycles, where L is the number of WAIT cycles before ack (L=0 if ack arrives in the first WAIT cycle). The op occupies 3+L cycles total.
- Non-memory instructions pass with zero stall.
- Back-to-back memory ops: the second op is detected in the IDLE cycle right after DONE, so every access is issued exactly once.
- mem_ack_i in IDLE or DONE is ignored.
- err_o stays set until reset.
- rdata_o holds its value between accesses.

Optional Feature:
DMEM_PERF_CNT_EN
- Defined: stall_cnt_o increments on every cycle with stall_o=1. access_cnt_o increments on every DONE entry, including timeouts. Both wrap at 2^32 and clear on reset.
- Undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Load, ack in first WAIT cycle (addr=0x4, rdata=0x5) -> stall_o high 2 cycles, rdata_o=5 in DONE, mem_req_o high exactly 1 cycle, mem_we_o=0.
- Store with ack 3 cycles into WAIT (addr=0x8, wdata=0x78) -> stall_o high 5 cycles, mem_we_o=1, mem_wdata_o=0x78 stable throughout, rdata_o unchanged.
- Two consecutive loads (0x0 then 0x4) -> two separate req pulses, no duplicate issue; access_cnt_o=2 with DMEM_PERF_CNT_EN, stall_cnt_o=4 with immediate acks.
- No ack, TIMEOUT_CYC=4 -> req drops after 4 WAIT cycles, err_o=1 sticky, rdata_o=0, pipeline resumes; a later ack pulse is ignored.
- rst_i asserted mid-WAIT -> all outputs 0 immediately (async); after release the FSM is in IDLE and no stale request is seen.
- start_i=0 with memRead_i=1 -> no request, stall_o=0; raising start_i -> access issues the same cycle.
